wb_periph_arbiter: RTL and testbench
====================================

Name: wb_periph_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter for the 16-bit embedded peripheral bus (GPIO, timers, UART).
- Masters: m0 is the CPU data port; m1 is a secondary master, e.g. a debug/DMA port.
- Grants bus ownership per whole cycle (cyc-held lock), with round-robin tie-breaking.
- Routes ack/read data only to the owner; optionally terminates stalled cycles with an error after a timeout.

Parameters:
- AW, 24, address width (matches `WB_ADDR_W`).
- DW, 16, data width.
- TIMEOUT, 255, cycles of unacked stb before error termination (optional feature only). Must be >= 2.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- m0_wb_cyc, m0_wb_stb, m0_wb_we  in  1 each  master 0 control
- m0_wb_adr  in  AW  master 0 address
- m0_wb_i_dat  in  DW  master 0 write data
- m0_wb_o_dat  out  DW  read data to master 0
- m0_wb_ack  out  1  ack to master 0
- m0_wb_err  out  1  error to master 0
- m1_*  same set as m0_*, for master 1
- s_wb_cyc, s_wb_stb, s_wb_we  out  1 each  slave control
- s_wb_adr  out  AW  slave address
- s_wb_o_dat  out  DW  write data to slave
- s_wb_i_dat  in  DW  slave read data
- s_wb_ack  in  1  slave ack
- grant  out  2  one-hot owner status: bit0 = m0, bit1 = m1; 00 = idle

Behaviour:
- Clocking: single clock i_clk. Reset i_rst is synchronous, active-high.
- Reset values:
  - state = IDLE; last = 1, so m0 wins the first tie; timeout counter = 0.
  - All outputs 0: s_wb_*, mX_wb_ack, mX_wb_err, mX_wb_o_dat, grant.
- Registered state: IDLE, GNT0, GNT1. All outputs are combinational from state plus inputs.
- IDLE:
  - Only m0_wb_cyc -> GNT0. Only m1_wb_cyc -> GNT1.
  - Both -> grant the master != last.
  - Neither -> stay IDLE.
  - Arbitration latency: 1 cycle. Request seen in cycle N gives ownership from cycle N+1.
- GNTx:
  - s_wb_cyc/stb/we/adr/o_dat = master x signals, unmodified.
  - mx_wb_ack = s_wb_ack; mx_wb_o_dat = s_wb_i_dat.
  - Non-owner: ack = 0, err = 0, o_dat = 0.
  - mx_wb_cyc high -> stay in GNTx. Multi-beat cycles keep ownership; the other master waits indefinitely.
  - mx_wb_cyc low:
    - s_wb_cyc = 0 this cycle; last <= x.
    - If the other master has cyc high -> go to GNT(other) next cycle (direct handoff, no IDLE bubble).
    - Else -> IDLE.
- stb without cyc is ignored (no grant, not forwarded).
- s_wb_ack arriving while in IDLE is discarded.
- grant = {state==GNT1, state==GNT0}.
- Reset mid-transaction: next cycle is IDLE with all outputs 0. The in-flight cycle is abandoned with no ack delivered.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - 8-bit counter (width = $clog2(TIMEOUT+1)).
  - Increments each cycle in GNTx with mx_wb_cyc & mx_wb_stb & !s_wb_ack.
  - Clears on ack, on stb low, or on leaving GNTx.
  - When the counter == TIMEOUT-1 and no ack, that cycle: mx_wb_err = 1 for one cycle, mx_wb_ack = 0, s_wb_stb forced 0, counter cleared.
  - Ownership is unchanged; the master decides whether to drop cyc.
- Undefined: no counter; m0_wb_err = m1_wb_err = 0 constantly; s_wb_stb is never gated.

Test Plan:
- Single master: m0 read, cyc/stb/adr=0x001010 in cycle 0; slave acks with dat=0x00A5 in cycle 2 -> grant=01 from cycle 1, s_wb_cyc=1 in cycles 1-2, m0_wb_ack=1 and m0_wb_o_dat=0x00A5 in cycle 2, m1_wb_ack=0 throughout.
- Tie after reset: m0 and m1 raise cyc in the same cycle -> GNT0 first. m0 drops cyc after its ack -> GNT1 the following cycle with no IDLE bubble. Next tie -> GNT0 (alternation).
- Lock: m1 owns and holds cyc across 3 write beats to 0x001011/0x001012 while m0 requests -> grant stays 10 for all beats. Slave sees m1 data (0x0055, 0x00FF). m0 is granted 1 cycle after m1 drops cyc.
- Isolation: m0 writes 0x1234 while m1 idles with stb=1, cyc=0 -> s_wb_o_dat=0x1234, s_wb_we=1, m1 never granted, m1 outputs all 0.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT=4): m0 strobes, slave never acks -> m0_wb_err=1 in exactly the 4th strobed cycle, s_wb_stb=0 that cycle, m0_wb_ack=0. Without the macro: err stays 0 and stb stays 1.
- Reset mid-op: i_rst=1 while in GNT1 -> next cycle grant=00, all s_wb_* = 0. After release with both requesting -> GNT0.

Source files
------------

// File: rtl/wb_periph_arbiter.sv
// Two-master / one-slave Wishbone arbiter with cyc-held lock and round-robin ties; optional stall timeout under WB_ARB_TIMEOUT_EN.
// Latency: 1 cycle from cyc to ownership; data/ack paths are combinational through the owner.
// Backpressure: a waiting master simply sees no ack until the owner drops cyc.
module wb_periph_arbiter #(
    parameter int AW      = 24,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,

    input  logic          m0_wb_cyc,
    input  logic          m0_wb_stb,
    input  logic          m0_wb_we,
    input  logic [AW-1:0] m0_wb_adr,
    input  logic [DW-1:0] m0_wb_i_dat,
    output logic [DW-1:0] m0_wb_o_dat,
    output logic          m0_wb_ack,
    output logic          m0_wb_err,

    input  logic          m1_wb_cyc,
    input  logic          m1_wb_stb,
    input  logic          m1_wb_we,
    input  logic [AW-1:0] m1_wb_adr,
    input  logic [DW-1:0] m1_wb_i_dat,
    output logic [DW-1:0] m1_wb_o_dat,
    output logic          m1_wb_ack,
    output logic          m1_wb_err,

    output logic          s_wb_cyc,
    output logic          s_wb_stb,
    output logic          s_wb_we,
    output logic [AW-1:0] s_wb_adr,
    output logic [DW-1:0] s_wb_o_dat,
    input  logic [DW-1:0] s_wb_i_dat,
    input  logic          s_wb_ack,

    output logic [1:0]    grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   own_cyc;
    logic   own_stb;
    logic   tmo_fire;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Ties go to the master that did not finish last; an owner dropping cyc
    // hands straight over to a waiting master without passing through IDLE.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_wb_cyc && m1_wb_cyc) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_wb_cyc) begin
                    state_d = GNT0;
                end else if (m1_wb_cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_wb_cyc) begin
                    last_d  = 1'b0;
                    state_d = m1_wb_cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_wb_cyc) begin
                    last_d  = 1'b1;
                    state_d = m0_wb_cyc ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        case (state_q)
            GNT0: begin
                own_cyc = m0_wb_cyc;
                own_stb = m0_wb_stb;
            end
            GNT1: begin
                own_cyc = m1_wb_cyc;
                own_stb = m1_wb_stb;
            end
            default: ;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_q, tmo_d;

    // Counts strobed, unacked owner cycles; any break in the stall restarts it.
    always_comb begin
        tmo_d    = '0;
        tmo_fire = 1'b0;
        if (own_cyc && own_stb && !s_wb_ack) begin
            if (tmo_q == CW'(TIMEOUT - 1)) begin
                tmo_fire = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        s_wb_cyc    = 1'b0;
        s_wb_stb    = 1'b0;
        s_wb_we     = 1'b0;
        s_wb_adr    = '0;
        s_wb_o_dat  = '0;
        m0_wb_ack   = 1'b0;
        m0_wb_err   = 1'b0;
        m0_wb_o_dat = '0;
        m1_wb_ack   = 1'b0;
        m1_wb_err   = 1'b0;
        m1_wb_o_dat = '0;
        case (state_q)
            GNT0: begin
                s_wb_cyc    = m0_wb_cyc;
                s_wb_stb    = own_cyc & own_stb & ~tmo_fire;
                s_wb_we     = m0_wb_we;
                s_wb_adr    = m0_wb_adr;
                s_wb_o_dat  = m0_wb_i_dat;
                m0_wb_ack   = s_wb_ack;
                m0_wb_err   = tmo_fire;
                m0_wb_o_dat = s_wb_i_dat;
            end
            GNT1: begin
                s_wb_cyc    = m1_wb_cyc;
                s_wb_stb    = own_cyc & own_stb & ~tmo_fire;
                s_wb_we     = m1_wb_we;
                s_wb_adr    = m1_wb_adr;
                s_wb_o_dat  = m1_wb_i_dat;
                m1_wb_ack   = s_wb_ack;
                m1_wb_err   = tmo_fire;
                m1_wb_o_dat = s_wb_i_dat;
            end
            default: ;
        endcase
    end

    assign grant = {state_q == GNT1, state_q == GNT0};

endmodule

// File: tb/tb_wb_periph_arbiter.sv
// Scoreboarded bench for wb_periph_arbiter: directed scenarios, then random traffic from both masters.
module tb_wb_periph_arbiter;
    localparam int AW = 24;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [1:0]          m_cyc, m_stb, m_we;
    logic [1:0][AW-1:0]  m_adr;
    logic [1:0][DW-1:0]  m_wdat;
    logic [1:0][DW-1:0]  m_rdat;
    logic [1:0]          m_ack, m_err;
    logic                s_cyc, s_stb, s_we;
    logic [AW-1:0]       s_adr;
    logic [DW-1:0]       s_odat;
    logic [DW-1:0]       s_dat;
    logic                s_ack;
    logic [1:0]          grant;

    logic                auto_slave;
    logic                dir_ack;
    logic [DW-1:0]       dir_dat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] wdat;
        logic [DW-1:0] rdat;
    } exp_t;

    exp_t exp0_q[$];
    exp_t exp1_q[$];

    wb_periph_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .m0_wb_cyc(m_cyc[0]), .m0_wb_stb(m_stb[0]), .m0_wb_we(m_we[0]),
        .m0_wb_adr(m_adr[0]), .m0_wb_i_dat(m_wdat[0]), .m0_wb_o_dat(m_rdat[0]),
        .m0_wb_ack(m_ack[0]), .m0_wb_err(m_err[0]),
        .m1_wb_cyc(m_cyc[1]), .m1_wb_stb(m_stb[1]), .m1_wb_we(m_we[1]),
        .m1_wb_adr(m_adr[1]), .m1_wb_i_dat(m_wdat[1]), .m1_wb_o_dat(m_rdat[1]),
        .m1_wb_ack(m_ack[1]), .m1_wb_err(m_err[1]),
        .s_wb_cyc(s_cyc), .s_wb_stb(s_stb), .s_wb_we(s_we), .s_wb_adr(s_adr),
        .s_wb_o_dat(s_odat), .s_wb_i_dat(s_dat), .s_wb_ack(s_ack),
        .grant(grant)
    );

    // Reference slave memory contents: a fixed function of the address.
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return ({a[7:0], a[15:8]} ^ a[23:8]) ^ 16'h5A3C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int id, input logic c, input logic s, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_cyc[id]  = c;
        m_stb[id]  = s;
        m_we[id]   = w;
        m_adr[id]  = a;
        m_wdat[id] = d;
    endtask

    task automatic push_exp(input int id, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW-1:0] rd);
        exp_t e;
        e.we = we; e.adr = a; e.wdat = wd; e.rdat = rd;
        if (id == 0) exp0_q.push_back(e);
        else         exp1_q.push_back(e);
    endtask

    task automatic chk_bus_idle(input string nm);
        chk({nm, " grant"}, 32'(grant), 0);
        chk({nm, " s_cyc"}, 32'(s_cyc), 0);
        chk({nm, " s_stb"}, 32'(s_stb), 0);
        chk({nm, " s_we"},  32'(s_we), 0);
        chk({nm, " s_adr"}, 32'(s_adr), 0);
        chk({nm, " s_odat"}, 32'(s_odat), 0);
        chk({nm, " m_ack"}, 32'(m_ack), 0);
        chk({nm, " m_err"}, 32'(m_err), 0);
        chk({nm, " m_rdat"}, 32'({m_rdat[1], m_rdat[0]}), 0);
    endtask

    // Random master: bursts of 1-3 beats per cyc, idle gaps in between.
    task automatic run_master(input int id, input int ntx);
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            waited;
        logic          done;
        for (int t = 0; t < ntx; t++) begin
            repeat ($urandom_range(0, 3)) step();
            for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
                we = 1'($urandom_range(0, 1));
                a  = AW'($urandom);
                d  = DW'($urandom);
                set_m(id, 1'b1, 1'b1, we, a, d);
                push_exp(id, we, a, d, mem_f(a));
                waited = 0;
                done   = 1'b0;
                while (!done && waited < 300) begin
                    @(negedge clk);
                    if (m_ack[id]) done = 1'b1;
                    else           waited++;
                end
                chk($sformatf("m%0d ack wait", id), 32'(done), 1);
                step();
            end
            set_m(id, 1'b0, 1'b0, 1'b0, '0, '0);
            step();
        end
    endtask

    // Slave model: directed mode replays dir_ack/dir_dat, auto mode acks with random wait states.
    initial begin
        int wcnt;
        s_ack = 1'b0;
        s_dat = '0;
        wcnt  = 0;
        forever begin
            @(posedge clk);
            #2;
            if (auto_slave) begin
                if (s_cyc && s_stb) begin
                    if (wcnt == 0) begin
                        s_ack = 1'b1;
                        s_dat = mem_f(s_adr);
                        wcnt  = $urandom_range(0, 2);
                    end else begin
                        s_ack = 1'b0;
                        wcnt--;
                    end
                end else begin
                    s_ack = 1'b0;
                end
            end else begin
                s_ack = dir_ack;
                s_dat = dir_dat;
            end
        end
    end

    // Monitor: pops the scoreboard on every master ack and checks isolation and lock each cycle.
    initial begin
        exp_t       e;
        logic       prev_hold;
        logic [1:0] prev_grant;
        prev_hold  = 1'b0;
        prev_grant = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                chk("grant not both", 32'(grant == 2'b11), 0);
                if (prev_hold) chk("lock held", 32'(grant), 32'(prev_grant));
                for (int i = 0; i < 2; i++) begin
                    if (!grant[i])
                        chk($sformatf("m%0d non-owner outputs", i),
                            32'({m_ack[i], m_err[i], m_rdat[i]}), 0);
                    if (m_ack[i]) begin
                        if ((i == 0 && exp0_q.size() == 0) || (i == 1 && exp1_q.size() == 0)) begin
                            chk($sformatf("m%0d stray ack", i), 32'(m_ack[i]), 0);
                        end else begin
                            if (i == 0) e = exp0_q.pop_front();
                            else        e = exp1_q.pop_front();
                            chk($sformatf("m%0d slave adr", i), 32'(s_adr), 32'(e.adr));
                            chk($sformatf("m%0d slave we", i), 32'(s_we), 32'(e.we));
                            if (e.we) chk($sformatf("m%0d slave wdat", i), 32'(s_odat), 32'(e.wdat));
                            else      chk($sformatf("m%0d rdat", i), 32'(m_rdat[i]), 32'(e.rdat));
                        end
                    end
                end
                prev_grant = grant;
                prev_hold  = (grant == 2'b01 && m_cyc[0]) || (grant == 2'b10 && m_cyc[1]);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] beat_adr [3];
        logic [DW-1:0] beat_dat [3];
        beat_adr[0] = 24'h001011; beat_dat[0] = 16'h0055;
        beat_adr[1] = 24'h001012; beat_dat[1] = 16'h00FF;
        beat_adr[2] = 24'h001011; beat_dat[2] = 16'h00AA;

        rst = 1'b1; auto_slave = 1'b0; dir_ack = 1'b1; dir_dat = 16'hDEAD;
        set_m(0, 0, 0, 0, '0, '0);
        set_m(1, 0, 0, 0, '0, '0);

        // Reset state, and a slave ack in IDLE goes nowhere.
        repeat (3) @(posedge clk);
        @(negedge clk); chk_bus_idle("reset");
        step(); rst = 1'b0;
        @(negedge clk); chk("idle ack dropped", 32'(m_ack), 0);
        step(); dir_ack = 1'b0;

        // Single m0 read.
        step(); set_m(0, 1, 1, 0, 24'h001010, '0); push_exp(0, 0, 24'h001010, '0, 16'h00A5);
        @(negedge clk); chk("rd c0 grant", 32'(grant), 0);
        step(); @(negedge clk);
        chk("rd c1 grant", 32'(grant), 1); chk("rd c1 s_cyc", 32'(s_cyc), 1);
        chk("rd c1 m0 ack", 32'(m_ack[0]), 0);
        step(); dir_ack = 1'b1; dir_dat = 16'h00A5; @(negedge clk);
        chk("rd c2 s_cyc", 32'(s_cyc), 1); chk("rd c2 m0 ack", 32'(m_ack[0]), 1);
        chk("rd c2 m0 dat", 32'(m_rdat[0]), 32'h00A5); chk("rd c2 m1 ack", 32'(m_ack[1]), 0);
        step(); dir_ack = 1'b0; set_m(0, 0, 0, 0, '0, '0); @(negedge clk);
        chk("rd c3 s_cyc", 32'(s_cyc), 0);
        step(); @(negedge clk); chk("rd c4 grant", 32'(grant), 0);

        // Tie after an m0 cycle goes to m1, which then holds the bus for three write beats.
        step();
        set_m(0, 1, 1, 0, 24'h000300, '0); push_exp(0, 0, 24'h000300, '0, 16'h0BEE);
        set_m(1, 1, 1, 1, beat_adr[0], beat_dat[0]);
        @(negedge clk); chk("lk c0 grant", 32'(grant), 0);
        for (int b = 0; b < 3; b++) begin
            step();
            set_m(1, 1, 1, 1, beat_adr[b], beat_dat[b]);
            push_exp(1, 1, beat_adr[b], beat_dat[b], '0);
            dir_ack = 1'b1; dir_dat = '0;
            @(negedge clk);
            chk($sformatf("lk beat%0d grant", b), 32'(grant), 2);
            chk($sformatf("lk beat%0d s_odat", b), 32'(s_odat), 32'(beat_dat[b]));
            chk($sformatf("lk beat%0d m0 ack", b), 32'(m_ack[0]), 0);
        end
        step(); set_m(1, 0, 0, 0, '0, '0); dir_ack = 1'b0; @(negedge clk);
        chk("lk drop grant", 32'(grant), 2); chk("lk drop s_cyc", 32'(s_cyc), 0);
        step(); dir_ack = 1'b1; dir_dat = 16'h0BEE; @(negedge clk);
        chk("lk m0 grant", 32'(grant), 1); chk("lk m0 ack", 32'(m_ack[0]), 1);
        step(); dir_ack = 1'b0; set_m(0, 0, 0, 0, '0, '0);
        step(); @(negedge clk); chk("lk end grant", 32'(grant), 0);

        // Tie after reset, direct handoff, then the next tie alternates back to m0.
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        set_m(0, 1, 1, 0, 24'h000010, '0); push_exp(0, 0, 24'h000010, '0, 16'h1111);
        set_m(1, 1, 1, 0, 24'h000020, '0); push_exp(1, 0, 24'h000020, '0, 16'h2222);
        @(negedge clk); chk("tie c0 grant", 32'(grant), 0);
        step(); dir_ack = 1'b1; dir_dat = 16'h1111; @(negedge clk);
        chk("tie first grant", 32'(grant), 1);
        step(); dir_ack = 1'b0; set_m(0, 0, 0, 0, '0, '0); @(negedge clk);
        chk("tie m0 drop grant", 32'(grant), 1);
        step(); dir_ack = 1'b1; dir_dat = 16'h2222; @(negedge clk);
        chk("tie handoff grant", 32'(grant), 2);
        step(); dir_ack = 1'b0; set_m(1, 0, 0, 0, '0, '0);
        step();
        set_m(0, 1, 1, 1, 24'h000030, 16'h3333); push_exp(0, 1, 24'h000030, 16'h3333, '0);
        set_m(1, 1, 1, 1, 24'h000040, 16'h4444); push_exp(1, 1, 24'h000040, 16'h4444, '0);
        @(negedge clk); chk("tie2 c0 grant", 32'(grant), 0);
        step(); dir_ack = 1'b1; @(negedge clk);
        chk("tie2 grant", 32'(grant), 1); chk("tie2 s_odat", 32'(s_odat), 32'h3333);
        step(); dir_ack = 1'b0; set_m(0, 0, 0, 0, '0, '0);
        step(); dir_ack = 1'b1; @(negedge clk); chk("tie2 m1 grant", 32'(grant), 2);
        step(); dir_ack = 1'b0; set_m(1, 0, 0, 0, '0, '0);
        step();

        // Isolation: m1 strobes without cyc while m0 writes.
        step();
        set_m(0, 1, 1, 1, 24'h000200, 16'h1234); push_exp(0, 1, 24'h000200, 16'h1234, '0);
        set_m(1, 0, 1, 0, 24'h000500, 16'h9999);
        step(); @(negedge clk);
        chk("iso s_odat", 32'(s_odat), 32'h1234); chk("iso s_we", 32'(s_we), 1);
        chk("iso grant", 32'(grant), 1);
        step(); dir_ack = 1'b1; @(negedge clk); chk("iso m0 ack", 32'(m_ack[0]), 1);
        step(); dir_ack = 1'b0; set_m(0, 0, 0, 0, '0, '0);
        step(); @(negedge clk); chk("iso m1 not granted", 32'(grant), 0);
        step(); @(negedge clk); chk("iso m1 still idle", 32'(grant), 0);
        set_m(1, 0, 0, 0, '0, '0);

        // Stalled slave: m0 strobes and nothing acks.
        step(); set_m(0, 1, 1, 0, 24'h000400, '0);
        for (int k = 1; k <= 6; k++) begin
            step(); @(negedge clk);
            chk($sformatf("tmo k%0d ack", k), 32'(m_ack[0]), 0);
`ifdef WB_ARB_TIMEOUT_EN
            chk($sformatf("tmo k%0d err", k), 32'(m_err[0]), 32'(k == 4));
            chk($sformatf("tmo k%0d s_stb", k), 32'(s_stb), 32'(k != 4));
`else
            chk($sformatf("tmo k%0d err", k), 32'(m_err[0]), 0);
            chk($sformatf("tmo k%0d s_stb", k), 32'(s_stb), 1);
`endif
        end
        step(); set_m(0, 0, 0, 0, '0, '0);
        step(); @(negedge clk); chk("tmo end grant", 32'(grant), 0);

        // Reset while m1 owns the bus.
        step(); set_m(1, 1, 1, 0, 24'h000600, '0);
        step(); @(negedge clk); chk("rmo grant m1", 32'(grant), 2);
        step(); rst = 1'b1; set_m(0, 1, 1, 0, 24'h000700, '0);
        step(); rst = 1'b0; @(negedge clk);
        chk_bus_idle("rmo after reset");
        push_exp(0, 0, 24'h000700, '0, 16'h0777);
        step(); dir_ack = 1'b1; dir_dat = 16'h0777; @(negedge clk);
        chk("rmo m0 grant", 32'(grant), 1); chk("rmo m0 ack", 32'(m_ack[0]), 1);
        step(); dir_ack = 1'b0; set_m(0, 0, 0, 0, '0, '0); set_m(1, 0, 0, 0, '0, '0);
        step(); step();
        chk("directed exp0 drained", 32'(exp0_q.size()), 0);
        chk("directed exp1 drained", 32'(exp1_q.size()), 0);

        // Random traffic from both masters against the auto slave.
        auto_slave = 1'b1;
        fork
            run_master(0, 40);
            run_master(1, 40);
        join
        repeat (4) step();
        chk("random exp0 drained", 32'(exp0_q.size()), 0);
        chk("random exp1 drained", 32'(exp1_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
